// File: rtl/pipe_stage_reg_if.sv
// Payload bundle crossing one pipeline register: valid bit, opaque payload, sticky side flag.
// master drives the bundle, slave consumes it.
interface pipe_stage_reg_if #(
  parameter int unsigned DATA_W = 128
) ();
  logic              valid;
  logic [DATA_W-1:0] data;
  logic              side;

  modport master (output valid, output data, output side);
  modport slave  (input  valid, input  data, input  side);
endinterface

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register obeying the shared stall vector and global flush,
// with saturating stall/bubble performance counters.
module pipe_stage_reg #(
  parameter int unsigned       DATA_W    = 128,
  parameter logic [DATA_W-1:0] NOP_VALUE = {DATA_W{1'b0}},
  parameter int unsigned       STAGE     = 2,
  parameter int unsigned       STALL_W   = 6,
  parameter int unsigned       CNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  input  logic               cnt_clr,
  pipe_stage_reg_if.slave    up,
  pipe_stage_reg_if.master   dn,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   bubble_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ACT_ADVANCE = 2'd0,
    ACT_HOLD    = 2'd1,
    ACT_BUBBLE  = 2'd2,
    ACT_FLUSH   = 2'd3
  } act_e;

  act_e              act_s;
  logic              valid_d, valid_q;
  logic [DATA_W-1:0] data_d, data_q;
  logic              side_d, side_q;
  logic [CNT_W-1:0]  stall_cnt_d, stall_cnt_q;
  logic [CNT_W-1:0]  bubble_cnt_d, bubble_cnt_q;
  logic              stall_unused_s;

  // Only our own stage bit and the downstream bit matter here.
  assign stall_unused_s = ^stall;

  // Classify the cycle into exactly one action, flush first.
  always_comb begin
    act_s = ACT_ADVANCE;
    if (flush) begin
      act_s = ACT_FLUSH;
    end else if (stall[STAGE]) begin
      if (stall[STAGE+1]) begin
        act_s = ACT_HOLD;
      end else begin
        act_s = ACT_BUBBLE;
      end
    end else begin
      act_s = ACT_ADVANCE;
    end
  end

  // Next payload state; the side flag survives a bubble so delay-slot status is kept.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    side_d  = side_q;
    case (act_s)
      ACT_FLUSH: begin
        valid_d = 1'b0;
        data_d  = NOP_VALUE;
        side_d  = 1'b0;
      end
      ACT_BUBBLE: begin
        valid_d = 1'b0;
        data_d  = NOP_VALUE;
      end
      ACT_HOLD: begin
        valid_d = valid_q;
      end
      ACT_ADVANCE: begin
        valid_d = up.valid;
        data_d  = up.valid ? up.data : NOP_VALUE;
        side_d  = up.side;
      end
      default: begin
        valid_d = 1'b0;
        data_d  = NOP_VALUE;
        side_d  = 1'b0;
      end
    endcase
  end

  // Saturating counters; a clear overrides any increment in the same cycle.
  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (cnt_clr) begin
      stall_cnt_d  = CNT_ZERO;
      bubble_cnt_d = CNT_ZERO;
    end else begin
      if (((act_s == ACT_HOLD) || (act_s == ACT_BUBBLE)) && (stall_cnt_q != CNT_MAX)) begin
        stall_cnt_d = stall_cnt_q + CNT_ONE;
      end else begin
        stall_cnt_d = stall_cnt_q;
      end
      if ((act_s == ACT_BUBBLE) && (bubble_cnt_q != CNT_MAX)) begin
        bubble_cnt_d = bubble_cnt_q + CNT_ONE;
      end else begin
        bubble_cnt_d = bubble_cnt_q;
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q      <= 1'b0;
      data_q       <= NOP_VALUE;
      side_q       <= 1'b0;
      stall_cnt_q  <= CNT_ZERO;
      bubble_cnt_q <= CNT_ZERO;
    end else begin
      valid_q      <= valid_d;
      data_q       <= data_d;
      side_q       <= side_d;
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign dn.valid   = valid_q;
  assign dn.data    = data_q;
  assign dn.side    = side_q;
  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed scenarios pinned with literal values,
// then randomized traffic checked every cycle against a behavioural model.
module tb_pipe_stage_reg;

  localparam int unsigned DW   = 128;
  localparam int unsigned SW   = 6;
  localparam int unsigned CW   = 4;
  localparam int          CMAX = 15;
  localparam logic [DW-1:0] NOP = 128'hFEED_0000_0000_0000_0000_0000_0000_F00D;

  logic          clk;
  logic          rst;
  logic [SW-1:0] stall;
  logic          flush;
  logic          cnt_clr;
  logic [CW-1:0] stall_cnt;
  logic [CW-1:0] bubble_cnt;

  pipe_stage_reg_if #(.DATA_W(DW)) up_if ();
  pipe_stage_reg_if #(.DATA_W(DW)) dn_if ();

  pipe_stage_reg #(
    .DATA_W(DW), .NOP_VALUE(NOP), .STAGE(2), .STALL_W(SW), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .cnt_clr(cnt_clr),
    .up(up_if), .dn(dn_if), .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit check_en = 1'b0;

  // Behavioural model of what the outputs must be.
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_side;
  int            m_scnt;
  int            m_bcnt;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_data  = NOP;
    m_side  = 1'b0;
    m_scnt  = 0;
    m_bcnt  = 0;
  endtask

  task automatic model_update();
    if (flush) begin
      m_valid = 1'b0; m_data = NOP; m_side = 1'b0;
    end else if (stall[2] && !stall[3]) begin
      m_valid = 1'b0; m_data = NOP;
      m_scnt = (m_scnt < CMAX) ? m_scnt + 1 : CMAX;
      m_bcnt = (m_bcnt < CMAX) ? m_bcnt + 1 : CMAX;
    end else if (stall[2]) begin
      m_scnt = (m_scnt < CMAX) ? m_scnt + 1 : CMAX;
    end else begin
      m_valid = up_if.valid;
      m_data  = up_if.valid ? up_if.data : NOP;
      m_side  = up_if.side;
    end
    if (cnt_clr) begin
      m_scnt = 0; m_bcnt = 0;
    end
  endtask

  // Single compare process: DUT against model on every falling edge.
  always @(negedge clk) begin
    if (check_en) begin
      check("m_valid", {{(DW-1){1'b0}}, dn_if.valid}, {{(DW-1){1'b0}}, m_valid});
      check("m_data", dn_if.data, m_data);
      check("m_side", {{(DW-1){1'b0}}, dn_if.side}, {{(DW-1){1'b0}}, m_side});
      check("m_stall_cnt", DW'(stall_cnt), DW'(m_scnt));
      check("m_bubble_cnt", DW'(bubble_cnt), DW'(m_bcnt));
    end
  end

  // One clock edge with the currently driven inputs; returns 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic drive(input logic [SW-1:0] st, input logic v, input logic [DW-1:0] d,
                       input logic sd, input logic fl, input logic clr);
    stall = st; up_if.valid = v; up_if.data = d; up_if.side = sd;
    flush = fl; cnt_clr = clr;
  endtask

  task automatic lit_out(input string name, input logic v, input logic [DW-1:0] d, input logic sd);
    check({name, "_valid"}, {{(DW-1){1'b0}}, dn_if.valid}, {{(DW-1){1'b0}}, v});
    check({name, "_data"}, dn_if.data, d);
    check({name, "_side"}, {{(DW-1){1'b0}}, dn_if.side}, {{(DW-1){1'b0}}, sd});
  endtask

  task automatic lit_cnt(input string name, input int sc, input int bc);
    check({name, "_stall_cnt"}, DW'(stall_cnt), DW'(sc));
    check({name, "_bubble_cnt"}, DW'(bubble_cnt), DW'(bc));
  endtask

  initial begin
    logic [DW-1:0] rd;
    drive(6'b000000, 1'b1, 128'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    model_reset();
    #1 rst = 1'b0;
    check_en = 1'b1;

    // Reset while an input is presented.
    repeat (3) @(negedge clk);
    lit_out("reset", 1'b0, NOP, 1'b0);
    lit_cnt("reset", 0, 0);
    rst = 1'b1;
    step();
    lit_out("first_load", 1'b1, 128'hDEAD_BEEF, 1'b0);

    // Advance stream.
    for (int i = 1; i <= 3; i++) begin
      drive(6'b000000, 1'b1, DW'(i), 1'b0, 1'b0, 1'b0);
      step();
      lit_out($sformatf("adv%0d", i), 1'b1, DW'(i), 1'b0);
    end
    drive(6'b000000, 1'b0, 128'h55, 1'b0, 1'b0, 1'b0);
    step();
    lit_out("adv_invalid", 1'b0, NOP, 1'b0);

    // Bubble keeps the side flag.
    drive(6'b000000, 1'b1, 128'h77, 1'b1, 1'b0, 1'b0);
    step();
    drive(6'b000100, 1'b1, 128'h88, 1'b0, 1'b0, 1'b0);
    step();
    lit_out("bubble", 1'b0, NOP, 1'b1);
    lit_cnt("bubble", 1, 1);

    // Hold freezes everything while inputs change.
    drive(6'b000000, 1'b1, 128'hABC, 1'b0, 1'b0, 1'b1);
    step();
    lit_cnt("clr_adv", 0, 0);
    for (int i = 0; i < 3; i++) begin
      drive(6'b001111, 1'b1, {$urandom, $urandom, $urandom, $urandom}, i[0], 1'b0, 1'b0);
      step();
    end
    lit_out("hold", 1'b1, 128'hABC, 1'b0);
    lit_cnt("hold", 3, 0);

    // Flush wins over a bubble pattern and does not count.
    drive(6'b000000, 1'b1, 128'h99, 1'b1, 1'b0, 1'b0);
    step();
    drive(6'b000100, 1'b1, 128'h11, 1'b1, 1'b1, 1'b0);
    step();
    lit_out("flush", 1'b0, NOP, 1'b0);
    lit_cnt("flush", 3, 0);
    drive(6'b001100, 1'b1, 128'h22, 1'b1, 1'b1, 1'b1);
    step();
    lit_cnt("flush_clr", 0, 0);

    // Saturation, then clear alongside a hold.
    drive(6'b001100, 1'b1, 128'h33, 1'b0, 1'b0, 1'b0);
    repeat (20) step();
    lit_cnt("sat_hold", 15, 0);
    cnt_clr = 1'b1;
    step();
    lit_cnt("clr_hold", 0, 0);
    drive(6'b000100, 1'b1, 128'h44, 1'b0, 1'b0, 1'b0);
    repeat (20) step();
    lit_cnt("sat_bubble", 15, 15);

    // Reset asserted mid-hold leaves no residue.
    drive(6'b000000, 1'b1, 128'h5A5A, 1'b1, 1'b0, 1'b0);
    step();
    drive(6'b001100, 1'b1, 128'h6B6B, 1'b0, 1'b0, 1'b0);
    repeat (2) step();
    #2 rst = 1'b0;
    model_reset();
    #1 lit_out("mid_reset", 1'b0, NOP, 1'b0);
    lit_cnt("mid_reset", 0, 0);
    @(negedge clk);
    rst = 1'b1;
    drive(6'b000000, 1'b1, 128'h1234, 1'b1, 1'b0, 1'b0);
    step();
    lit_out("post_reset", 1'b1, 128'h1234, 1'b1);
    lit_cnt("post_reset", 0, 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      rd = {$urandom, $urandom, $urandom, $urandom};
      drive(SW'($urandom), 1'($urandom), rd, 1'($urandom),
            ($urandom_range(0, 15) == 0), ($urandom_range(0, 31) == 0));
      step();
    end

    @(negedge clk);
    check_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
